// File: rtl/serial_parity_rx.sv
// serial_parity_rx
// ----------------
// Receives bit-serial frames of 9 bits: 8 data bits LSB-first, then one
// parity bit. Each completed frame is checked against the configured parity.
// The byte is then presented on a single-entry valid/ready output buffer with
// a parity error flag.
//
// Parameters
//   PARITY_ODD : 0 = even parity (XOR of data and parity bit is 0),
//                1 = odd parity  (XOR of data and parity bit is 1)
//
// Ports
//   clk        in   rising-edge clock, sole clock domain
//   rst_n      in   synchronous active-low reset
//   sin_valid  in   serial bit present on sin_data
//   sin_data   in   serial bit
//   sin_sof    in   current bit is bit 0 of a new frame
//   sin_ready  out  receiver accepts a bit this cycle (combinational)
//   dout       out  received byte
//   dout_valid out  dout/dout_perr hold a byte
//   dout_ready in   consumer accepts the byte on dout
//   dout_perr  out  parity mismatch for the byte on dout
//   sync_err   out  one-cycle pulse: stray bit in IDLE or frame aborted by sof
//   perr_cnt   out  saturating count of parity errors since reset

module serial_parity_rx #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin_valid,
    input  logic       sin_data,
    input  logic       sin_sof,
    output logic       sin_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_perr,
    output logic       sync_err,
    output logic [7:0] perr_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [2:0] bidx, bidx_n;
    logic [7:0] shift, shift_n;
    logic       sync_err_n;
    logic       load;
    logic       perr;
    logic       accept;

    // Only the parity bit can refill the output buffer, so it is the only
    // bit that ever has to wait for the consumer.
    assign sin_ready = !(state == PARITY && dout_valid && !dout_ready);
    assign accept    = sin_valid && sin_ready;

    // Frame assembly: decides the next state, the shift register contents,
    // whether a sync error is flagged and whether a finished byte loads.
    always_comb begin
        state_n    = state;
        bidx_n     = bidx;
        shift_n    = shift;
        sync_err_n = 1'b0;
        load       = 1'b0;
        perr       = ((^shift) ^ sin_data) != PARITY_ODD;

        if (accept) begin
            if (sin_sof) begin
                // A start bit always begins a fresh frame; anything partial
                // is thrown away and reported.
                shift_n    = {7'd0, sin_data};
                bidx_n     = 3'd1;
                state_n    = DATA;
                sync_err_n = (state != IDLE);
            end else begin
                unique case (state)
                    IDLE: begin
                        sync_err_n = 1'b1;
                    end
                    DATA: begin
                        shift_n[bidx] = sin_data;
                        bidx_n        = bidx + 3'd1;
                        if (bidx == 3'd7) begin
                            state_n = PARITY;
                        end
                    end
                    PARITY: begin
                        load    = 1'b1;
                        bidx_n  = 3'd0;
                        state_n = IDLE;
                    end
                    default: begin
                        state_n = IDLE;
                    end
                endcase
            end
        end
    end

    // Receive-side state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bidx     <= 3'd0;
            shift    <= 8'd0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_n;
            bidx     <= bidx_n;
            shift    <= shift_n;
            sync_err <= sync_err_n;
        end
    end

    // Single-entry output buffer and parity error counter. A load in the same
    // cycle as a handshake wins, so valid stays high with the new byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= 8'd0;
            dout_valid <= 1'b0;
            dout_perr  <= 1'b0;
            perr_cnt   <= 8'd0;
        end else if (load) begin
            dout       <= shift;
            dout_perr  <= perr;
            dout_valid <= 1'b1;
            if (perr && perr_cnt != 8'hFF) begin
                perr_cnt <= perr_cnt + 8'd1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx
// -------------------
// Drives directed frames into two receivers (even and odd parity) and checks
// the even one every cycle against a frame-level model that collects bits in
// a queue, plus literal expectations at key points of each scenario.

module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sin_valid, sin_data, sin_sof;
    logic       sin_ready, sin_ready_o;
    logic [7:0] dout, dout_o;
    logic       dout_valid, dout_valid_o;
    logic       dout_ready;
    logic       dout_perr, dout_perr_o;
    logic       sync_err, sync_err_o;
    logic [7:0] perr_cnt, perr_cnt_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_parity_rx #(.PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .sin_valid(sin_valid), .sin_data(sin_data), .sin_sof(sin_sof),
        .sin_ready(sin_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_perr(dout_perr), .sync_err(sync_err), .perr_cnt(perr_cnt)
    );

    serial_parity_rx #(.PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n),
        .sin_valid(sin_valid), .sin_data(sin_data), .sin_sof(sin_sof),
        .sin_ready(sin_ready_o),
        .dout(dout_o), .dout_valid(dout_valid_o), .dout_ready(dout_ready),
        .dout_perr(dout_perr_o), .sync_err(sync_err_o), .perr_cnt(perr_cnt_o)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model: bits are gathered in a queue; nine of them make a byte.
    bit       q[$];
    bit       m_valid = 1'b0;
    bit [7:0] m_dout  = 8'd0;
    bit       m_perr  = 1'b0;
    bit       m_sync  = 1'b0;
    int       m_cnt   = 0;

    always @(posedge clk) begin
        bit       rdy;
        bit [7:0] b;
        int       ones;
        if (!rst_n) begin
            q.delete();
            m_valid = 1'b0; m_dout = 8'd0; m_perr = 1'b0; m_sync = 1'b0; m_cnt = 0;
        end else begin
            rdy    = !(q.size() == 8 && m_valid && !dout_ready);
            m_sync = 1'b0;
            if (m_valid && dout_ready) m_valid = 1'b0;
            if (sin_valid && rdy) begin
                if (sin_sof) begin
                    if (q.size() != 0) m_sync = 1'b1;
                    q.delete();
                    q.push_back(sin_data);
                end else if (q.size() == 0) begin
                    m_sync = 1'b1;
                end else begin
                    q.push_back(sin_data);
                    if (q.size() == 9) begin
                        ones = 0;
                        for (int i = 0; i < 9; i++) ones += int'(q[i]);
                        for (int i = 0; i < 8; i++) b[i] = q[i];
                        m_dout  = b;
                        m_perr  = (ones % 2) != 0;
                        m_valid = 1'b1;
                        if (m_perr && m_cnt < 255) m_cnt++;
                        q.delete();
                    end
                end
            end
        end
    end

    // Per-cycle comparison, just after each edge once the model has settled.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            checkOutput("cyc_valid", int'(dout_valid), int'(m_valid));
            checkOutput("cyc_sync", int'(sync_err), int'(m_sync));
            checkOutput("cyc_cnt", int'(perr_cnt), m_cnt);
            checkOutput("cyc_ready", int'(sin_ready),
                        int'(!(q.size() == 8 && m_valid && !dout_ready)));
            checkOutput("cyc_ready_odd", int'(sin_ready_o),
                        int'(!(q.size() == 8 && m_valid && !dout_ready)));
            if (m_valid) begin
                checkOutput("cyc_dout", int'(dout), int'(m_dout));
                checkOutput("cyc_perr", int'(dout_perr), int'(m_perr));
                checkOutput("cyc_dout_odd", int'(dout_o), int'(m_dout));
            end
        end
    end

    // Counts observed byte transfers and sync pulses for scenario-level checks.
    int       xfers = 0;
    int       syncs = 0;
    bit [7:0] last_byte = 8'd0;

    always @(posedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            xfers++;
            last_byte = dout;
        end
        if (sync_err) syncs++;
    end

    // Drive one input cycle; a valid bit is held until the receiver is ready.
    task automatic applyStimulus(input logic v, input logic s, input logic d);
        int n;
        @(negedge clk);
        sin_valid = v; sin_sof = s; sin_data = d;
        #1;
        n = 0;
        while (v && !sin_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (v && !sin_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: sin_ready got 0, expected 1 at %0t", $time);
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic par, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8) applyStimulus(1'b1, i == 0, b[i]);
            else       applyStimulus(1'b1, 1'b0, par);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    int x0, s0;

    initial begin
        rst_n = 1'b0; sin_valid = 1'b0; sin_sof = 1'b0; sin_data = 1'b0; dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_valid", int'(dout_valid), 0);
        checkOutput("rst_cnt", int'(perr_cnt), 0);
        checkOutput("rst_sync", int'(sync_err), 0);
        checkOutput("rst_dout", int'(dout), 8'h00);
        chk_en = 1'b1;

        // Even parity good frame; valid appears the cycle after the parity bit.
        sendFrame(8'hA5, 1'b0, 9);
        checkOutput("a5_not_yet", int'(dout_valid), 0);
        idle(1);
        checkOutput("a5_valid", int'(dout_valid), 1);
        checkOutput("a5_dout", int'(dout), 8'hA5);
        checkOutput("a5_perr", int'(dout_perr), 0);
        checkOutput("a5_cnt", int'(perr_cnt), 0);
        checkOutput("a5_odd_perr", int'(dout_perr_o), 1);

        // Parity error in even mode, clean in odd mode.
        sendFrame(8'h01, 1'b0, 9);
        idle(1);
        checkOutput("e01_dout", int'(dout), 8'h01);
        checkOutput("e01_perr", int'(dout_perr), 1);
        checkOutput("e01_cnt", int'(perr_cnt), 1);
        checkOutput("e01_odd_perr", int'(dout_perr_o), 0);
        idle(2);

        // Backpressure: first byte held, second parity bit stalls.
        x0 = xfers;
        dout_ready = 1'b0;
        sendFrame(8'h3C, 1'b0, 9);
        sendFrame(8'hC3, 1'b0, 8);
        @(negedge clk);
        sin_valid = 1'b1; sin_sof = 1'b0; sin_data = 1'b0;
        #1;
        checkOutput("bp_ready_low", int'(sin_ready), 0);
        checkOutput("bp_hold_dout", int'(dout), 8'h3C);
        checkOutput("bp_hold_valid", int'(dout_valid), 1);
        @(negedge clk);
        checkOutput("bp_still_3c", int'(dout), 8'h3C);
        dout_ready = 1'b1;
        #1;
        checkOutput("bp_ready_high", int'(sin_ready), 1);
        idle(1);
        checkOutput("bp_c3_dout", int'(dout), 8'hC3);
        checkOutput("bp_c3_valid", int'(dout_valid), 1);
        checkOutput("bp_c3_perr", int'(dout_perr), 0);
        idle(2);
        checkOutput("bp_xfers", xfers - x0, 2);
        checkOutput("bp_last", int'(last_byte), 8'hC3);

        // Resync: partial frame aborted by a new start bit.
        x0 = xfers; s0 = syncs;
        sendFrame(8'h0F, 1'b0, 4);
        sendFrame(8'h5A, 1'b0, 9);
        idle(3);
        checkOutput("rs_syncs", syncs - s0, 1);
        checkOutput("rs_xfers", xfers - x0, 1);
        checkOutput("rs_last", int'(last_byte), 8'h5A);

        // Stray bit in IDLE.
        x0 = xfers; s0 = syncs;
        applyStimulus(1'b1, 1'b0, 1'b1);
        idle(1);
        checkOutput("stray_sync_now", int'(sync_err), 1);
        idle(2);
        checkOutput("stray_syncs", syncs - s0, 1);
        checkOutput("stray_xfers", xfers - x0, 0);

        // Saturation of the parity error counter.
        for (int f = 0; f < 260; f++) sendFrame(8'h01, 1'b0, 9);
        idle(2);
        checkOutput("sat_cnt", int'(perr_cnt), 255);

        // Reset with a byte pending and a frame half received.
        dout_ready = 1'b0;
        sendFrame(8'h11, 1'b0, 9);
        sendFrame(8'hFF, 1'b0, 5);
        @(negedge clk);
        rst_n = 1'b0; sin_valid = 1'b0; sin_sof = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rr_valid", int'(dout_valid), 0);
        checkOutput("rr_cnt", int'(perr_cnt), 0);
        checkOutput("rr_sync", int'(sync_err), 0);
        dout_ready = 1'b1;
        sendFrame(8'h77, 1'b0, 9);
        idle(1);
        checkOutput("rr_77_dout", int'(dout), 8'h77);
        checkOutput("rr_77_valid", int'(dout_valid), 1);
        checkOutput("rr_77_perr", int'(dout_perr), 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
